// File: rtl/regfile_pkg.sv
// Shared defaults and types for the decode-stage register file.
package regfile_pkg;

    localparam int unsigned REGFILE_NUM_REGS = 32;
    localparam int unsigned REGFILE_WIDTH    = 64;
    localparam int unsigned REGFILE_ZERO_IDX = 31;
    localparam int unsigned AW               = $clog2(REGFILE_NUM_REGS);

    typedef logic [AW-1:0]            reg_idx_t;
    typedef logic [REGFILE_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/regfile_rdmux_pipe_if.sv
// Write and multi-port read bus of the register file.
interface regfile_rdmux_pipe_if #(
    parameter int unsigned NUM_REGS = regfile_pkg::REGFILE_NUM_REGS,
    parameter int unsigned WIDTH    = regfile_pkg::REGFILE_WIDTH,
    parameter int unsigned NUM_RD   = 2
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic                      wr_en;
    logic [IDX_W-1:0]          wr_addr;
    logic [WIDTH-1:0]          wr_data;
    logic [NUM_RD-1:0]         rd_req;
    logic [NUM_RD*IDX_W-1:0]   rd_addr;
    logic [NUM_RD*WIDTH-1:0]   rd_data;
    logic [NUM_RD-1:0]         rd_valid;

    modport master (
        output wr_en, wr_addr, wr_data, rd_req, rd_addr,
        input  rd_data, rd_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_req, rd_addr,
        output rd_data, rd_valid
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: NUM_REGS:1 selector, zero/bypass override, output registers.
// Write-through on a same-edge collision when REGFILE_BYPASS_EN is defined.
module regfile_rd_port #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned ZERO_IDX = 31
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             rd_req,
    input  logic [$clog2(NUM_REGS)-1:0]      rd_addr,
    input  logic [WIDTH-1:0]                 mem [NUM_REGS],
    input  logic                             wr_en,
    input  logic [$clog2(NUM_REGS)-1:0]      wr_addr,
    input  logic [WIDTH-1:0]                 wr_data,
    output logic [WIDTH-1:0]                 rd_data,
    output logic                             rd_valid
);
    logic [WIDTH-1:0] sel_d;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_comb begin
        sel_d = '0;
        if (32'(rd_addr) < NUM_REGS) begin
            sel_d = mem[rd_addr];
        end
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr)) begin
            sel_d = wr_data;
        end
`endif
        // XZR wins over both storage and bypass
        if (32'(rd_addr) == ZERO_IDX) begin
            sel_d = '0;
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_req;
            if (rd_req) begin
                data_q <= sel_d;
            end
        end
    end

    assign rd_data  = data_q;
    assign rd_valid = valid_q;

    addr_in_range: assert property (@(posedge clk) disable iff (!reset_n)
        rd_req |-> (32'(rd_addr) < NUM_REGS));

endmodule

// File: rtl/regfile_rdmux_pipe.sv
// Register file with NUM_RD registered read ports; owns storage and write decode.
// Optional macro REGFILE_BYPASS_EN selects write-through on read/write collisions.
module regfile_rdmux_pipe
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = REGFILE_NUM_REGS,
    parameter int unsigned WIDTH    = REGFILE_WIDTH,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_IDX = REGFILE_ZERO_IDX
) (
    input logic                 clk,
    input logic                 reset_n,
    regfile_rdmux_pipe_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    logic [WIDTH-1:0] mem_q [NUM_REGS];
    logic             wr_hit;

    assign wr_hit = bus.wr_en && (32'(bus.wr_addr) != ZERO_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_hit) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd_port
        regfile_rd_port #(
            .NUM_REGS (NUM_REGS),
            .WIDTH    (WIDTH),
            .ZERO_IDX (ZERO_IDX)
        ) u_rd_port (
            .clk      (clk),
            .reset_n  (reset_n),
            .rd_req   (bus.rd_req[p]),
            .rd_addr  (bus.rd_addr[p*IDX_W +: IDX_W]),
            .mem      (mem_q),
            .wr_en    (bus.wr_en),
            .wr_addr  (bus.wr_addr),
            .wr_data  (bus.wr_data),
            .rd_data  (bus.rd_data[p*WIDTH +: WIDTH]),
            .rd_valid (bus.rd_valid[p])
        );
    end

endmodule

// File: tb/tb_regfile_rdmux_pipe.sv
// Directed bench for regfile_rdmux_pipe; a 2-port and a 4-port instance share write traffic.
module tb_regfile_rdmux_pipe;
    import regfile_pkg::*;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;
    reg_word_t model [32];

    regfile_rdmux_pipe_if #(.NUM_REGS(32), .WIDTH(64), .NUM_RD(2)) bus2 ();
    regfile_rdmux_pipe_if #(.NUM_REGS(32), .WIDTH(64), .NUM_RD(4)) bus4 ();

    regfile_rdmux_pipe #(.NUM_REGS(32), .WIDTH(64), .NUM_RD(2), .ZERO_IDX(31)) u_dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    regfile_rdmux_pipe #(.NUM_REGS(32), .WIDTH(64), .NUM_RD(4), .ZERO_IDX(31)) u_dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] d2(input int p);
        return bus2.rd_data[p*64 +: 64];
    endfunction

    function automatic logic [63:0] d4(input int p);
        return bus4.rd_data[p*64 +: 64];
    endfunction

    task automatic set_wr(input logic en, input int idx, input logic [63:0] d);
        bus2.wr_en   = en;
        bus2.wr_addr = 5'(idx);
        bus2.wr_data = d;
        bus4.wr_en   = en;
        bus4.wr_addr = 5'(idx);
        bus4.wr_data = d;
        if (en && idx != 31) model[idx] = d;
    endtask

    task automatic wr(input int idx, input logic [63:0] d);
        set_wr(1'b1, idx, d);
        tick();
        set_wr(1'b0, 0, 64'h0);
    endtask

    task automatic rd2(input logic [1:0] req, input int a0, input int a1);
        bus2.rd_req  = req;
        bus2.rd_addr = {5'(a1), 5'(a0)};
    endtask

    initial begin
        logic [63:0] exp_col;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = '0;
        set_wr(1'b0, 0, 64'h0);
        rd2(2'b00, 0, 0);
        bus4.rd_req  = '0;
        bus4.rd_addr = '0;
        tick();
        tick();
        check_eq("rst_valid", 64'(bus2.rd_valid), 64'h0);
        check_eq("rst_data", bus2.rd_data[63:0], 64'h0);
        reset_n = 1'b1;

        // Write then read on port 0, one-cycle latency
        wr(5, 64'hDEAD_BEEF_0123_4567);
        rd2(2'b01, 5, 0);
        tick();
        check_eq("wr_rd_data0", d2(0), 64'hDEAD_BEEF_0123_4567);
        check_eq("wr_rd_valid", 64'(bus2.rd_valid), 64'h1);
        rd2(2'b00, 0, 0);
        tick();
        check_eq("idle_valid", 64'(bus2.rd_valid), 64'h0);
        check_eq("idle_hold", d2(0), 64'hDEAD_BEEF_0123_4567);

        // Async reset in the middle of a read
        rd2(2'b01, 5, 0);
        tick();
        check_eq("pre_rst_valid", 64'(bus2.rd_valid), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 64'(bus2.rd_valid), 64'h0);
        check_eq("mid_rst_data", d2(0), 64'h0);
        for (int i = 0; i < 32; i++) model[i] = '0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rd2(2'b11, i, (i + 1) % 32);
            tick();
            check_eq("post_rst_p0", d2(0), 64'h0);
            check_eq("post_rst_p1", d2(1), 64'h0);
        end

        // Zero register ignores writes
        wr(31, 64'hFFFF_FFFF_FFFF_FFFF);
        rd2(2'b11, 31, 31);
        tick();
        check_eq("xzr_p0", d2(0), 64'h0);
        check_eq("xzr_p1", d2(1), 64'h0);
        check_eq("xzr_valid", 64'(bus2.rd_valid), 64'h3);

        // Same-edge read/write collision
        wr(7, 64'h11);
        set_wr(1'b1, 7, 64'h22);
        rd2(2'b01, 7, 0);
        tick();
        set_wr(1'b0, 0, 64'h0);
`ifdef REGFILE_BYPASS_EN
        exp_col = 64'h22;
`else
        exp_col = 64'h11;
`endif
        check_eq("collide_same", d2(0), exp_col);
        tick();
        check_eq("collide_next", d2(0), 64'h22);

        // Both ports on one index, then port 1 idle
        wr(3, 64'h3333_0000_0000_3333);
        rd2(2'b11, 3, 3);
        tick();
        check_eq("dual_p0", d2(0), 64'h3333_0000_0000_3333);
        check_eq("dual_p1", d2(1), 64'h3333_0000_0000_3333);
        rd2(2'b01, 7, 5);
        tick();
        check_eq("dual_p0_next", d2(0), 64'h22);
        check_eq("dual_p1_hold", d2(1), 64'h3333_0000_0000_3333);
        check_eq("dual_valid", 64'(bus2.rd_valid), 64'h1);
        rd2(2'b00, 0, 0);

        // Random fill, then rotated reads on every port of both instances
        for (int i = 0; i < 31; i++) wr(i, {$urandom, $urandom});
        for (int i = 0; i < 32; i++) begin
            rd2(2'b11, i, (i + 1) % 32);
            bus4.rd_req = 4'hF;
            for (int p = 0; p < 4; p++) bus4.rd_addr[p*5 +: 5] = 5'((i + p) % 32);
            tick();
            for (int p = 0; p < 2; p++) check_eq("sweep2", d2(p), model[(i + p) % 32]);
            for (int p = 0; p < 4; p++) check_eq("sweep4", d4(p), model[(i + p) % 32]);
        end
        check_eq("sweep4_valid", 64'(bus4.rd_valid), 64'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
